// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - iterative radix-2 shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU)
// Includes the generate/propagate adder that forms each partial-product step.

module adder_cla #(
    parameter int W = 33
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o
);
    logic [W-1:0] gen;
    logic [W-1:0] prop;

    assign gen  = a_i & b_i;
    assign prop = a_i ^ b_i;

    always_comb begin : carry_chain
        logic [W:0] carry;
        carry    = '0;
        for (int i = 0; i < W; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
        sum_o = prop ^ carry[W-1:0];
    end
endmodule

module mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_kill,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] OP_MUL = 2'b00;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     sum, upper_next;
    logic [2*WIDTH-1:0] prod_fix;

    // Only the high-word ops interpret operands as signed; MUL's low word is sign-agnostic.
    assign a_signed = (i_op == 2'b01) || (i_op == 2'b10);
    assign b_signed = (i_op == 2'b01);
    assign a_neg    = a_signed & i_a[WIDTH-1];
    assign b_neg    = b_signed & i_b[WIDTH-1];
    assign abs_a    = a_neg ? (~i_a + 1'b1) : i_a;
    assign abs_b    = b_neg ? (~i_b + 1'b1) : i_b;

    adder_cla #(.W(WIDTH+1)) u_add (
        .a_i   ({1'b0, acc_q[2*WIDTH-1:WIDTH]}),
        .b_i   ({1'b0, mcand_q}),
        .sum_o (sum)
    );

    assign prod_fix = (neg_q && (op_q != OP_MUL)) ? (~acc_q + 1'b1) : acc_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        neg_d      = neg_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        upper_next = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        o_ready    = (state_q == S_IDLE);
        o_valid    = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    op_d     = i_op;
                    mcand_d  = abs_a;
                    mplier_d = abs_b;
                    neg_d    = a_neg ^ b_neg;
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH - 1);
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (mplier_q[0]) begin
                    upper_next = sum;
                end
                // The adder carry becomes the new MSB as the whole accumulator shifts right.
                acc_d    = {upper_next, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = (op_q == OP_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (i_kill && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign o_result = result_q;
endmodule
